transition_trace_collector: RTL and testbench
=============================================

# transition_trace_collector

Capture-side companion to the masked-gate correlation stimulus. The stimulus applies an input vector pair `{a,b,r1,r2}` (from → to) to a gate-under-test and pulses a marker. This block samples the gate output `y` for a fixed window after each marker and counts the output toggles (glitches) in that window. It emits one record per transition on a valid/ready stream, keeps a sticky overrun flag, and keeps a running toggle total for correlation post-processing.

## Interface
Parameters:
- `IN_W`, 4, width of the from/to vectors (`{a,b,r1,r2}`).
- `WINDOW`, 8, capture window length in clock cycles; must be ≥ 1.
- `CNT_W`, 8, width of the per-record toggle counter.
- `SIM_W`, 16, width of the transition index.

Ports:
- `clk`  in  1  sampling clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `mark`  in  1  one-cycle pulse; the to-vector is applied to the DUT in this cycle.
- `vec_from`  in  IN_W  previous vector; valid while `mark` = 1.
- `vec_to`  in  IN_W  applied vector; valid while `mark` = 1.
- `y`  in  1  DUT output; asynchronous to `clk`.
- `busy`  out  1  1 when not IDLE.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts the record.
- `rec_sim`  out  SIM_W  transition index of the record.
- `rec_from`  out  IN_W  latched `vec_from`.
- `rec_to`  out  IN_W  latched `vec_to`.
- `rec_toggles`  out  CNT_W  output toggles counted in the window, saturating.
- `rec_final`  out  1  synchronized `y` at the last window cycle.
- `overrun`  out  1  sticky; set when a `mark` is dropped.
- `total_toggles`  out  32  saturating sum of all accepted `rec_toggles`.

## Operation
- `y` passes through a 2-flop synchronizer to give `y_s`. The second flop's previous value is kept as `y_p`.
- The FSM has three states: IDLE, CAPTURE, REPORT.
- IDLE:
  - On `mark`, latch `vec_from` and `vec_to`.
  - Set the toggle count to 0 and the window counter to `WINDOW`.
  - Go to CAPTURE.
- CAPTURE:
  - Each cycle, if `y_s != y_p`, the toggle count increments. It holds at 2^CNT_W−1.
  - The window counter decrements each cycle.
  - When the window counter reaches 1:
    - load the `rec_*` outputs, with `rec_final` taken from the current `y_s`;
    - set `rec_valid`;
    - go to REPORT.
- REPORT:
  - `rec_*` hold stable while `rec_valid` is 1 and `rec_ready` is 0.
  - On `rec_valid && rec_ready`:
    - `rec_valid` clears;
    - `rec_sim` increments (wraps at 2^SIM_W);
    - `total_toggles` adds `rec_toggles` (saturating at 2^32−1);
    - go to IDLE.
- `mark` in CAPTURE or REPORT is ignored and sets `overrun`. This includes `mark` in the same cycle as the REPORT handshake.
- `overrun` clears only on `rst`.
- Reset:
  - All outputs are 0 and the FSM is in IDLE. `rec_sim` is 0 and `total_toggles` is 0.
  - Both synchronizer flops are reset to 0.
  - Reset asserted mid-window or mid-report discards the record in progress.

## Timing
- Cycle 0 is the `mark` cycle.
- Toggles are counted in cycles 1..WINDOW.
- `rec_valid` rises at the clock edge ending cycle WINDOW. It is visible in cycle WINDOW+1, so latency is WINDOW+1 cycles from `mark` to `rec_valid`.
- A `y` edge appears in `y_s` 2–3 cycles after it occurs. Edges later than WINDOW−2 cycles after `mark` may be missed; the window length is chosen to cover this.
- Minimum `mark` spacing is WINDOW+2 cycles when `rec_ready` is held at 1.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `CORR_TOTAL_EN` defined:
  - the 32-bit `total_toggles` accumulator is present;
  - it updates on each record handshake.
- `CORR_TOTAL_EN` undefined:
  - the accumulator is not built;
  - `total_toggles` is tied to 0;
  - all other behaviour is identical.

## Test plan
All scenarios use defaults (`WINDOW`=8, `CNT_W`=8) unless stated.
1. Reset → `rec_valid`=0, `busy`=0, `overrun`=0, `rec_sim`=0, `total_toggles`=0.
2. `mark` with `vec_from`=4'h3, `vec_to`=4'hC, `y` held 0 → `rec_valid` in cycle 9. Record: `rec_toggles`=0, `rec_final`=0, `rec_from`=3, `rec_to`=C, `rec_sim`=0.
3. `y` goes 0→1→0→1 in cycles 1, 3, 5, `rec_ready`=1 → `rec_toggles`=3, `rec_final`=1. After the handshake, `rec_sim`=1 and `total_toggles`=3.
4. `rec_ready`=0 for 5 cycles after `rec_valid`, with a `mark` pulsed in that period → record stable, `overrun`=1. `rec_sim` increments only at the handshake, and the dropped `mark` produces no record.
5. `CNT_W`=2, `y` toggling every cycle through the window → `rec_toggles`=3 (saturated).
6. `rst` pulsed in cycle 4 of CAPTURE → all outputs 0. The next `mark` gives a record with `rec_sim`=0. Repeat with `CORR_TOTAL_EN` undefined → `total_toggles`=0 throughout.

Source files
------------

// File: rtl/transition_trace_collector_if.sv
// Record stream from the transition trace collector to its consumer.
// Latency: none (signal bundle only).
// Backpressure: valid/ready; the master holds all rec_* stable while rec_valid && !rec_ready.
//
// Ports (master = collector side):
//   rec_valid   out  record available
//   rec_ready   in   consumer accepts the record
//   rec_sim     out  transition index of the record
//   rec_from    out  latched previous vector
//   rec_to      out  latched applied vector
//   rec_toggles out  saturating toggle count in the window
//   rec_final   out  synchronized y at the last window cycle
interface transition_trace_collector_if #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 8,
    parameter int SIM_W = 16
);
    logic             rec_valid;
    logic             rec_ready;
    logic [SIM_W-1:0] rec_sim;
    logic [IN_W-1:0]  rec_from;
    logic [IN_W-1:0]  rec_to;
    logic [CNT_W-1:0] rec_toggles;
    logic             rec_final;

    modport master (
        output rec_valid, rec_sim, rec_from, rec_to, rec_toggles, rec_final,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_sim, rec_from, rec_to, rec_toggles, rec_final,
        output rec_ready
    );
endinterface

// File: rtl/transition_trace_collector.sv
// Counts gate-output toggles in a fixed window after each stimulus marker and emits one record per transition.
// Latency: rec_valid is visible WINDOW+1 cycles after the mark cycle.
// Backpressure: record held until rec_ready; marks arriving while busy are dropped and set sticky overrun.
//
// Ports:
//   clk, rst            sampling clock; asynchronous active-high reset
//   mark                one-cycle pulse, vec_from/vec_to valid with it
//   vec_from, vec_to    previous and applied stimulus vectors {a,b,r1,r2}
//   y                   gate output, asynchronous to clk
//   busy                registered (state != IDLE)
//   rec                 record stream (master modport)
//   overrun             sticky, a mark was dropped; cleared only by rst
//   total_toggles       saturating sum of accepted rec_toggles
// Build option: define CORR_TOTAL_EN to build the total_toggles accumulator;
// otherwise total_toggles is tied to 0.
module transition_trace_collector #(
    parameter int IN_W   = 4,
    parameter int WINDOW = 8,
    parameter int CNT_W  = 8,
    parameter int SIM_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mark,
    input  logic [IN_W-1:0]               vec_from,
    input  logic [IN_W-1:0]               vec_to,
    input  logic                          y,
    output logic                          busy,
    transition_trace_collector_if.master  rec,
    output logic                          overrun,
    output logic [31:0]                   total_toggles
);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             y_m;
    logic             y_s;
    logic             y_p;
    logic             toggle;
    logic             hs;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIN_W-1:0] win;
    logic             last_cycle;
    logic [IN_W-1:0]  lat_from;
    logic [IN_W-1:0]  lat_to;

    assign toggle     = y_s ^ y_p;
    assign hs         = rec.rec_valid && rec.rec_ready;
    assign last_cycle = (win == WIN_W'(1));
    // Counter saturates rather than wrapping so a glitchy gate never reads as quiet.
    assign cnt_nxt    = (toggle && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mark)       state_nxt = CAPTURE;
            CAPTURE: if (last_cycle) state_nxt = REPORT;
            REPORT:  if (hs)         state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // y is asynchronous: two-flop synchronizer, then y_p keeps the previous y_s for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_m <= 1'b0;
            y_s <= 1'b0;
            y_p <= 1'b0;
        end else begin
            y_m <= y;
            y_s <= y_m;
            y_p <= y_s;
        end
    end

    // Capture datapath and record stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun         <= 1'b0;
            cnt             <= '0;
            win             <= '0;
            lat_from        <= '0;
            lat_to          <= '0;
            rec.rec_valid   <= 1'b0;
            rec.rec_sim     <= '0;
            rec.rec_from    <= '0;
            rec.rec_to      <= '0;
            rec.rec_toggles <= '0;
            rec.rec_final   <= 1'b0;
        end else begin
            // A mark while not IDLE is dropped, including one coinciding with the report handshake.
            if (mark && (state != IDLE))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (mark) begin
                        lat_from <= vec_from;
                        lat_to   <= vec_to;
                        cnt      <= '0;
                        win      <= WIN_W'(WINDOW);
                    end
                end
                CAPTURE: begin
                    cnt <= cnt_nxt;
                    win <= win - 1'b1;
                    // Final window cycle: its own toggle is included via cnt_nxt.
                    if (last_cycle) begin
                        rec.rec_from    <= lat_from;
                        rec.rec_to      <= lat_to;
                        rec.rec_toggles <= cnt_nxt;
                        rec.rec_final   <= y_s;
                        rec.rec_valid   <= 1'b1;
                    end
                end
                REPORT: begin
                    if (hs) begin
                        rec.rec_valid <= 1'b0;
                        rec.rec_sim   <= rec.rec_sim + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CORR_TOTAL_EN
    logic [32:0] total_sum;

    // One spare bit catches overflow so the total clamps at all-ones.
    assign total_sum = {1'b0, total_toggles} + 33'(rec.rec_toggles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            total_toggles <= '0;
        else if (hs)
            total_toggles <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
    end
`else
    assign total_toggles = '0;
`endif

endmodule

// File: tb/tb_transition_trace_collector.sv
module tb_transition_trace_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        mark;
    logic [3:0]  vf;
    logic [3:0]  vt;
    logic        y;
    logic        busy;
    logic        overrun;
    logic [31:0] total;

    logic        mark2;
    logic        y2;
    logic        busy2;
    logic        overrun2;
    logic [31:0] total2;

    int compared   = 0;
    int mismatched = 0;

`ifdef CORR_TOTAL_EN
    localparam bit TOT_EN = 1'b1;
`else
    localparam bit TOT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    transition_trace_collector_if #(.IN_W(4), .CNT_W(8), .SIM_W(16)) rif ();
    transition_trace_collector_if #(.IN_W(4), .CNT_W(2), .SIM_W(16)) rif2 ();

    transition_trace_collector #(.IN_W(4), .WINDOW(8), .CNT_W(8), .SIM_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .mark          (mark),
        .vec_from      (vf),
        .vec_to        (vt),
        .y             (y),
        .busy          (busy),
        .rec           (rif),
        .overrun       (overrun),
        .total_toggles (total)
    );

    transition_trace_collector #(.IN_W(4), .WINDOW(8), .CNT_W(2), .SIM_W(16)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .mark          (mark2),
        .vec_from      (4'h1),
        .vec_to        (4'h2),
        .y             (y2),
        .busy          (busy2),
        .rec           (rif2),
        .overrun       (overrun2),
        .total_toggles (total2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; mark = 1'b0; vf = 4'h0; vt = 4'h0; y = 1'b0;
        mark2 = 1'b0; y2 = 1'b0;
        rif.rec_ready = 1'b0; rif2.rec_ready = 1'b0;
        ticks(2);
        rst = 1'b0;

        // 1: reset state
        chk("rst_valid",   32'(rif.rec_valid),   32'd0);
        chk("rst_busy",    32'(busy),            32'd0);
        chk("rst_overrun", 32'(overrun),         32'd0);
        chk("rst_sim",     32'(rif.rec_sim),     32'd0);
        chk("rst_total",   total,                32'd0);
        chk("rst_toggles", 32'(rif.rec_toggles), 32'd0);

        // 2: quiet y, latency and record contents, consumer stalled
        tick();
        mark = 1'b1; vf = 4'h3; vt = 4'hC;            // cycle 0
        tick();
        mark = 1'b0; vf = 4'h0; vt = 4'h0;            // cycle 1
        chk("t2_busy_c1", 32'(busy), 32'd1);
        ticks(7);                                      // cycle 8
        chk("t2_valid_c8", 32'(rif.rec_valid), 32'd0);
        tick();                                        // cycle 9
        chk("t2_valid_c9", 32'(rif.rec_valid),   32'd1);
        chk("t2_toggles",  32'(rif.rec_toggles), 32'd0);
        chk("t2_final",    32'(rif.rec_final),   32'd0);
        chk("t2_from",     32'(rif.rec_from),    32'h3);
        chk("t2_to",       32'(rif.rec_to),      32'hC);
        chk("t2_sim",      32'(rif.rec_sim),     32'd0);
        rif.rec_ready = 1'b1;
        tick();                                        // cycle 10, after handshake
        chk("t2_valid_hs", 32'(rif.rec_valid), 32'd0);
        chk("t2_sim_hs",   32'(rif.rec_sim),   32'd1);
        chk("t2_busy_hs",  32'(busy),          32'd0);

        // 3: y 0->1->0->1 in cycles 1,3,5, ready held high, back-to-back mark spacing
        mark = 1'b1; vf = 4'h5; vt = 4'h6;            // cycle 0
        tick(); mark = 1'b0; y = 1'b1;                 // cycle 1
        ticks(2); y = 1'b0;                            // cycle 3
        ticks(2); y = 1'b1;                            // cycle 5
        ticks(4);                                      // cycle 9
        chk("t3_valid",   32'(rif.rec_valid),   32'd1);
        chk("t3_toggles", 32'(rif.rec_toggles), 32'd3);
        chk("t3_final",   32'(rif.rec_final),   32'd1);
        chk("t3_sim",     32'(rif.rec_sim),     32'd1);
        tick();                                        // cycle 10
        chk("t3_valid_hs", 32'(rif.rec_valid), 32'd0);
        chk("t3_sim_hs",   32'(rif.rec_sim),   32'd2);
        chk("t3_total",    total,              TOT_EN ? 32'd3 : 32'd0);
        chk("t3_overrun",  32'(overrun),       32'd0);

        // 4: stalled consumer for 5 cycles with a mark dropped in REPORT
        rif.rec_ready = 1'b0;
        mark = 1'b1; vf = 4'hA; vt = 4'h5;            // cycle 0
        tick(); mark = 1'b0;                           // cycle 1
        ticks(8);                                      // cycle 9
        chk("t4_valid",   32'(rif.rec_valid),   32'd1);
        chk("t4_toggles", 32'(rif.rec_toggles), 32'd0);
        chk("t4_final",   32'(rif.rec_final),   32'd1);
        ticks(2); mark = 1'b1; vf = 4'hF; vt = 4'hF;  // cycle 11
        tick(); mark = 1'b0;                           // cycle 12
        chk("t4_overrun", 32'(overrun), 32'd1);
        tick();                                        // cycle 13
        chk("t4_hold_valid", 32'(rif.rec_valid),   32'd1);
        chk("t4_hold_from",  32'(rif.rec_from),    32'hA);
        chk("t4_hold_to",    32'(rif.rec_to),      32'h5);
        chk("t4_hold_sim",   32'(rif.rec_sim),     32'd2);
        chk("t4_hold_tog",   32'(rif.rec_toggles), 32'd0);
        rif.rec_ready = 1'b1;
        tick();                                        // cycle 14
        chk("t4_valid_hs", 32'(rif.rec_valid), 32'd0);
        chk("t4_sim_hs",   32'(rif.rec_sim),   32'd3);
        chk("t4_total",    total,              TOT_EN ? 32'd3 : 32'd0);
        ticks(12);
        chk("t4_no_extra_valid", 32'(rif.rec_valid), 32'd0);
        chk("t4_no_extra_busy",  32'(busy),          32'd0);
        chk("t4_no_extra_sim",   32'(rif.rec_sim),   32'd3);
        chk("t4_overrun_sticky", 32'(overrun),       32'd1);

        // 5: CNT_W=2 instance, y toggling every cycle of the window
        rif2.rec_ready = 1'b1;
        mark2 = 1'b1;                                  // cycle 0
        tick(); mark2 = 1'b0;                          // cycle 1
        for (int k = 1; k <= 8; k++) begin
            y2 = k[0];
            tick();
        end                                            // cycle 9
        chk("t5_valid",   32'(rif2.rec_valid),   32'd1);
        chk("t5_toggles", 32'(rif2.rec_toggles), 32'd3);
        chk("t5_final",   32'(rif2.rec_final),   32'd0);
        chk("t5_overrun", 32'(overrun2),         32'd0);

        // 6: reset in cycle 4 of CAPTURE discards the record
        y = 1'b0;
        ticks(4);
        mark = 1'b1; vf = 4'h7; vt = 4'h8;            // cycle 0
        tick(); mark = 1'b0;                           // cycle 1
        ticks(3);                                      // cycle 4
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid",   32'(rif.rec_valid),   32'd0);
        chk("t6_rst_busy",    32'(busy),            32'd0);
        chk("t6_rst_overrun", 32'(overrun),         32'd0);
        chk("t6_rst_sim",     32'(rif.rec_sim),     32'd0);
        chk("t6_rst_total",   total,                32'd0);
        chk("t6_rst_toggles", 32'(rif.rec_toggles), 32'd0);
        chk("t6_rst_from",    32'(rif.rec_from),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        mark = 1'b1; vf = 4'h9; vt = 4'hE;            // cycle 0
        tick(); mark = 1'b0; y = 1'b1;                 // cycle 1
        ticks(8);                                      // cycle 9
        chk("t6_valid",   32'(rif.rec_valid),   32'd1);
        chk("t6_sim",     32'(rif.rec_sim),     32'd0);
        chk("t6_toggles", 32'(rif.rec_toggles), 32'd1);
        chk("t6_final",   32'(rif.rec_final),   32'd1);
        chk("t6_from",    32'(rif.rec_from),    32'h9);
        chk("t6_to",      32'(rif.rec_to),      32'hE);
        tick();                                        // cycle 10
        chk("t6_sim_hs",   32'(rif.rec_sim),   32'd1);
        chk("t6_valid_hs", 32'(rif.rec_valid), 32'd0);
        chk("t6_total",    total,              TOT_EN ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
